// File: rtl/parallel_in_sr_pkg.sv
// Shared definitions for the parallel-in, serial-out byte shift register:
// FSM state type, byte width and the counter-width helper.
package parallel_in_sr_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ceiling log2; callers pass DEPTH+1 so a count of DEPTH always fits.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/parallel_in_sr_load_sr_unit.sv
// One byte slot of the shift chain: loads either its parallel byte or its
// upstream neighbour when enabled, cleared asynchronously by reset.
module load_sr_unit
    import parallel_in_sr_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_par,
    input  logic [BYTE_W-1:0] i_shift_in,
    output logic [BYTE_W-1:0] o_q
);

    logic [BYTE_W-1:0] r_q;

    // NOTE: the slots are reset (not left as uninitialised storage) because
    // shift_out must read 8'h00 while reset is held; sequential state uses
    // non-blocking assignments so every slot samples its neighbour's old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_load ? i_par : i_shift_in;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/parallel_in_sr.sv
// Parallel-in, serial-out byte shift register with valid/ready on both sides;
// slot DEPTH-1 is emitted first so a matching SIPO reproduces the word.
module parallel_in_sr
    import parallel_in_sr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BYTE_W*DEPTH-1:0] p_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [BYTE_W-1:0]       shift_out,
    output logic                    shift_valid,
    input  logic                    shift_ready,
    output logic                    busy
);

    localparam int                CNT_W    = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [BYTE_W-1:0] w_slot [DEPTH];
    logic              w_last;
    logic              w_load;
    logic              w_xfer;
    logic              w_en;

    assign w_last      = (r_count == CNT_ONE);
    assign shift_valid = (r_state == SHIFT);
    assign busy        = (r_state == SHIFT);
    // A word can be accepted while the last byte of the previous one leaves.
    assign load_ready  = (r_state == IDLE) || (w_last && shift_ready);
    assign w_load      = load_valid && load_ready;
    assign w_xfer      = shift_valid && shift_ready;
    assign w_en        = w_load || w_xfer;
    assign shift_out   = w_slot[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [BYTE_W-1:0] w_shift_in;
        if (g == 0) begin : g_tail
            assign w_shift_in = '0;
        end else begin : g_body
            assign w_shift_in = w_slot[g-1];
        end

        load_sr_unit u_unit (
            .clock      (clock),
            .reset      (reset),
            .i_en       (w_en),
            .i_load     (w_load),
            .i_par      (p_in[g*BYTE_W +: BYTE_W]),
            .i_shift_in (w_shift_in),
            .o_q        (w_slot[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // NOTE: both next-state values get a hold default first, so no path through
    // this block leaves them unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = CNT_FULL;
                end
            end
            SHIFT: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_count_nxt = r_count - CNT_ONE;
                    end else if (w_load) begin
                        w_count_nxt = CNT_FULL;
                    end else begin
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_parallel_in_sr.sv
// Directed bench for parallel_in_sr: a DEPTH=4 instance driven from a vector
// table plus hand sequences, and a DEPTH=1 instance for the single-byte case.
module tb_parallel_in_sr;

    logic        clock;
    logic        reset;

    logic [31:0] p_in;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  shift_out;
    logic        shift_valid;
    logic        shift_ready;
    logic        busy;

    logic [7:0]  d1_p_in;
    logic        d1_load_valid;
    logic        d1_load_ready;
    logic [7:0]  d1_shift_out;
    logic        d1_shift_valid;
    logic        d1_shift_ready;
    logic        d1_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sipo;

    parallel_in_sr #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .p_in        (p_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .shift_out   (shift_out),
        .shift_valid (shift_valid),
        .shift_ready (shift_ready),
        .busy        (busy)
    );

    parallel_in_sr #(.DEPTH(1)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .p_in        (d1_p_in),
        .load_valid  (d1_load_valid),
        .load_ready  (d1_load_ready),
        .shift_out   (d1_shift_out),
        .shift_valid (d1_shift_valid),
        .shift_ready (d1_shift_ready),
        .busy        (d1_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        lv;
        logic [31:0] p;
        logic        sr;
        logic        ev;
        logic [7:0]  eo;
        logic        elr;
        logic        eb;
        logic        chk_pout;
        logic [31:0] epout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic lv, input logic [31:0] p, input logic sr,
                       input logic ev, input logic [7:0] eo, input logic elr,
                       input logic eb);
        vec_t v;
        v.lv = lv; v.p = p; v.sr = sr; v.ev = ev; v.eo = eo; v.elr = elr; v.eb = eb;
        v.chk_pout = 1'b0; v.epout = '0;
        vecs.push_back(v);
    endtask

    // Idle row that also checks the word rebuilt by the downstream register.
    task automatic add_idle_pout(input logic [31:0] epout);
        vec_t v;
        v.lv = 1'b0; v.p = '0; v.sr = 1'b1; v.ev = 1'b0; v.eo = 8'h00; v.elr = 1'b1; v.eb = 1'b0;
        v.chk_pout = 1'b1; v.epout = epout;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [7:0] eo,
                                 input logic elr, input logic eb);
        check({tag, ".shift_valid"}, {31'd0, shift_valid}, {31'd0, ev});
        check({tag, ".shift_out"},   {24'd0, shift_out},   {24'd0, eo});
        check({tag, ".load_ready"},  {31'd0, load_ready},  {31'd0, elr});
        check({tag, ".busy"},        {31'd0, busy},        {31'd0, eb});
    endtask

    logic [7:0] mid_bytes [4];
    logic [7:0] d1_prev;

    initial begin
        reset          = 1'b0;
        p_in           = '0;
        load_valid     = 1'b0;
        shift_ready    = 1'b0;
        d1_p_in        = '0;
        d1_load_valid  = 1'b0;
        d1_shift_ready = 1'b0;
        sipo           = '0;

        // Single word, full rate.
        add(1, 32'h44332211, 1, 0, 8'h00, 1, 0);
        add(0, 32'h0,        1, 1, 8'h44, 0, 1);
        add(0, 32'h0,        1, 1, 8'h33, 0, 1);
        add(0, 32'h0,        1, 1, 8'h22, 0, 1);
        add(0, 32'h0,        1, 1, 8'h11, 1, 1);
        add_idle_pout(32'h44332211);
        // Backpressure on the first byte for three cycles.
        add(1, 32'h44332211, 1, 0, 8'h00, 1, 0);
        add(0, 32'h0,        0, 1, 8'h44, 0, 1);
        add(0, 32'h0,        0, 1, 8'h44, 0, 1);
        add(0, 32'h0,        0, 1, 8'h44, 0, 1);
        add(0, 32'h0,        1, 1, 8'h44, 0, 1);
        add(0, 32'h0,        1, 1, 8'h33, 0, 1);
        add(0, 32'h0,        1, 1, 8'h22, 0, 1);
        add(0, 32'h0,        0, 1, 8'h11, 0, 1);
        add(0, 32'h0,        1, 1, 8'h11, 1, 1);
        add_idle_pout(32'h44332211);
        // Back-to-back words; a mid-word load (count 3) must be dropped.
        add(1, 32'h44332211, 1, 0, 8'h00, 1, 0);
        add(0, 32'h0,        1, 1, 8'h44, 0, 1);
        add(1, 32'h12345678, 1, 1, 8'h33, 0, 1);
        add(0, 32'h0,        1, 1, 8'h22, 0, 1);
        add(1, 32'hDDCCBBAA, 1, 1, 8'h11, 1, 1);
        add(0, 32'h0,        1, 1, 8'hDD, 0, 1);
        add(0, 32'h0,        1, 1, 8'hCC, 0, 1);
        add(0, 32'h0,        1, 1, 8'hBB, 0, 1);
        add(0, 32'h0,        1, 1, 8'hAA, 1, 1);
        add_idle_pout(32'hDDCCBBAA);

        // Reset held for three cycles, checked while asserted and after release.
        repeat (3) @(posedge clock);
        #1;
        check_outputs("in_reset", 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("after_reset", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            load_valid  = vecs[i].lv;
            p_in        = vecs[i].p;
            shift_ready = vecs[i].sr;
            @(negedge clock);
            check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].elr, vecs[i].eb);
            if (vecs[i].chk_pout)
                check($sformatf("vec%0d.p_out", i), sipo, vecs[i].epout);
            if (shift_valid && shift_ready)
                sipo = {sipo[23:0], shift_out};
            @(posedge clock);
            #1;
        end

        // Reset mid-word after two bytes have left.
        load_valid  = 1'b1;
        p_in        = 32'h44332211;
        shift_ready = 1'b1;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        p_in       = '0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_outputs("pre_midreset", 1'b1, 8'h22, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_outputs("midreset", 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        mid_bytes[0] = 8'h0F; mid_bytes[1] = 8'h0E; mid_bytes[2] = 8'h0D; mid_bytes[3] = 8'h0C;
        load_valid = 1'b1;
        p_in       = 32'h0F0E0D0C;
        @(negedge clock);
        check_outputs("post_reset_load", 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        p_in       = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_outputs($sformatf("post_reset_byte%0d", i), 1'b1, mid_bytes[i], i == 3, 1'b1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check_outputs("post_reset_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clock);
        #1;

        // DEPTH=1: a fresh byte accepted and emitted every cycle.
        d1_load_valid  = 1'b1;
        d1_shift_ready = 1'b1;
        d1_prev        = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d1_p_in = 8'h5A + 8'(i * 17);
            @(negedge clock);
            check($sformatf("d1_%0d.load_ready", i), {31'd0, d1_load_ready}, 32'd1);
            check($sformatf("d1_%0d.shift_valid", i), {31'd0, d1_shift_valid}, {31'd0, i != 0});
            check($sformatf("d1_%0d.shift_out", i), {24'd0, d1_shift_out}, {24'd0, d1_prev});
            d1_prev = d1_p_in;
            @(posedge clock);
            #1;
        end
        d1_load_valid = 1'b0;
        @(negedge clock);
        check("d1_tail.shift_out", {24'd0, d1_shift_out}, {24'd0, d1_prev});
        check("d1_tail.busy", {31'd0, d1_busy}, 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("d1_idle.shift_valid", {31'd0, d1_shift_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
